pipe_hazard_ctrl: RTL
=====================

Name: pipe_hazard_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS pipeline. Consumes the hazard unit's load-use flag, the EX-stage branch/jump redirect, the multi-cycle MDU start, and the WB-stage halt (syscall). Drives the PC and pipeline-register enable/clear strobes. Optional performance counters feed the board display.

Parameters:
MDU_LAT, 4, total EX-stage occupancy in cycles of a mult/div instruction; legal range 2..255
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
load_use  in  1  load-use hazard from the forwarding unit (ID depends on a load in EX)
redirect_ex  in  1  branch taken or jump resolved in EX; PC is being redirected
mdu_start_ex  in  1  mult/div instruction present in EX
halt_wb  in  1  syscall halt instruction present in WB
go  in  1  resume pulse from the board button, already debounced
pc_en  out  1  PC register write enable
ifid_en  out  1  IF/ID write enable
ifid_clr  out  1  IF/ID synchronous clear (inserts a bubble)
idex_en  out  1  ID/EX write enable
idex_clr  out  1  ID/EX synchronous clear
exmem_en  out  1  EX/MEM write enable
exmem_clr  out  1  EX/MEM synchronous clear
memwb_en  out  1  MEM/WB write enable
mdu_done  out  1  high in the cycle the MDU result leaves EX
halted  out  1  high while in HALT
cycle_cnt  out  CNT_W  cycles spent outside HALT
stall_cnt  out  CNT_W  non-HALT cycles with pc_en=0
flush_cnt  out  CNT_W  redirect events accepted
lu_cnt  out  CNT_W  load-use stalls inserted

Behaviour:
- Clock and reset: single clock clk. Reset rst is synchronous and active-high.
- States: RUN, MDU_WAIT, HALT. Reset -> RUN, mdu_cnt=0, resume_mask=0, all counters 0.
- Reset output values: all *_en=1, all *_clr=0, mdu_done=0, halted=0.
- Outputs are combinational from state, registers, and current inputs, with no extra latency.
- Normal (RUN, no event): all *_en=1, all *_clr=0.
- halt_wb_q = halt_wb & ~resume_mask.
- Per-cycle priority in RUN:
  1. halt_wb_q: this cycle's outputs stay normal, so WB commits. Next state is HALT.
  2. redirect_ex: ifid_clr=1 and idex_clr=1; pc_en=1 so the target loads. A load_use in the same cycle is discarded because the ID instruction is squashed. flush_cnt increments.
  3. mdu_start_ex: pc_en, ifid_en and idex_en are 0; exmem_clr=1 (bubble into MEM); memwb_en=1. mdu_cnt<=MDU_LAT-1 and next state is MDU_WAIT. If MDU_LAT==2, mdu_cnt<=1.
  4. load_use: pc_en=0, ifid_en=0, idex_clr=1 for exactly one cycle. lu_cnt increments.
- MDU_WAIT:
  - Outputs are the same hold pattern as the entry cycle, and mdu_cnt decrements.
  - When mdu_cnt==1: release cycle. Outputs are normal, mdu_done=1, next state RUN.
  - EX occupancy equals MDU_LAT cycles, entry cycle included.
  - mdu_start_ex, load_use and redirect_ex are ignored in MDU_WAIT, including the release cycle.
  - halt_wb_q has priority: next state HALT and mdu_cnt is cleared. After resume the MDU instruction re-triggers its full latency.
- HALT:
  - All *_en=0, all *_clr=0, halted=1.
  - go -> RUN, with resume_mask<=1 for exactly one cycle so the syscall still in WB advances without re-halting.
  - go outside HALT is ignored.
- rst in any state or mid-MDU returns to RUN immediately and clears mdu_cnt and the counters.
- stall_cnt counts every non-HALT cycle with pc_en=0.
- All counters wrap at 2^CNT_W.

Optional Feature:
PIPE_PERF_CNT_EN.
- Defined: the four counters are implemented as specified.
- Undefined: the counter registers are not built, and cycle_cnt, stall_cnt, flush_cnt and lu_cnt are tied to 0.
- Control behaviour is identical in both builds.

Test Plan:
- Reset, then 10 idle cycles -> all *_en=1, all *_clr=0, halted=0; cycle_cnt=10 with PIPE_PERF_CNT_EN.
- load_use pulse for 1 cycle -> that cycle pc_en=0, ifid_en=0, idex_clr=1; next cycle normal; lu_cnt=1, stall_cnt=1.
- load_use and redirect_ex in the same cycle -> ifid_clr=1, idex_clr=1, pc_en=1; lu_cnt unchanged, flush_cnt=1.
- MDU_LAT=4, mdu_start_ex held high 4 cycles:
  - cycles 0-2: pc_en=0, idex_en=0, exmem_clr=1.
  - cycle 3: mdu_done=1 with normal enables.
  - stall_cnt=3.
- halt_wb high, held while halted -> next cycle halted=1 and all enables 0, for 20 cycles. go pulse -> one cycle with halt masked and normal enables. halt_wb then dropped -> stays in RUN.
- rst asserted during MDU_WAIT with mdu_cnt=2 -> next cycle RUN, normal outputs, mdu_done=0, counters 0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Purpose : stall/flush sequencer for the 5-stage MIPS pipeline (PC and pipeline-register enables/clears).
// Latency : control outputs are combinational from state and current inputs; counters update one cycle later.
// Backpressure: a mult/div holds IF/ID/EX for MDU_LAT cycles; a syscall halt freezes everything until go.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   load_use, redirect_ex,    hazard / redirect / mult-div / syscall event inputs
//   mdu_start_ex, halt_wb
//   go                        debounced resume pulse, only honoured while halted
//   pc_en, *_en, *_clr        PC and pipeline-register write enables and synchronous clears
//   mdu_done                  cycle in which the mult/div result leaves EX
//   halted                    high while halted
//   cycle_cnt .. lu_cnt       performance counters (built only with PIPE_PERF_CNT_EN defined,
//                             otherwise tied to zero)
module pipe_hazard_ctrl #(
    parameter int MDU_LAT = 4,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_use,
    input  logic             redirect_ex,
    input  logic             mdu_start_ex,
    input  logic             halt_wb,
    input  logic             go,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_clr,
    output logic             idex_en,
    output logic             idex_clr,
    output logic             exmem_en,
    output logic             exmem_clr,
    output logic             memwb_en,
    output logic             mdu_done,
    output logic             halted,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] lu_cnt
);

    typedef enum logic [1:0] {RUN, MDU_WAIT, HALT} state_t;

    // Remaining EX cycles loaded on entry; the entry cycle itself is the first
    // of the MDU_LAT occupancy cycles, so MDU_LAT-1 are left to count.
    localparam logic [7:0] MDU_LOAD = 8'(MDU_LAT - 1);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] mdu_cnt;
    logic [7:0] mdu_cnt_nxt;
    logic       resume_mask;
    logic       halt_q;
    logic       hold;

    // The syscall that caused the halt is still in WB on the first cycle after
    // resume; masking it for that one cycle lets it retire instead of re-halting.
    assign halt_q = halt_wb & ~resume_mask;

    always_comb begin
        pc_en       = 1'b1;
        ifid_en     = 1'b1;
        ifid_clr    = 1'b0;
        idex_en     = 1'b1;
        idex_clr    = 1'b0;
        exmem_en    = 1'b1;
        exmem_clr   = 1'b0;
        memwb_en    = 1'b1;
        mdu_done    = 1'b0;
        halted      = 1'b0;
        hold        = 1'b0;
        state_nxt   = state;
        mdu_cnt_nxt = mdu_cnt;

        case (state)
            RUN: begin
                if (halt_q) begin
                    // Outputs stay normal so the syscall commits in WB this cycle.
                    state_nxt = HALT;
                end else if (redirect_ex) begin
                    // Squash IF and ID; a concurrent load_use refers to the squashed
                    // ID instruction and is therefore dropped.
                    ifid_clr = 1'b1;
                    idex_clr = 1'b1;
                end else if (mdu_start_ex) begin
                    hold        = 1'b1;
                    mdu_cnt_nxt = MDU_LOAD;
                    state_nxt   = MDU_WAIT;
                end else if (load_use) begin
                    pc_en    = 1'b0;
                    ifid_en  = 1'b0;
                    idex_clr = 1'b1;
                end
            end
            MDU_WAIT: begin
                if (halt_q) begin
                    // Keep the mult/div parked in EX; it restarts its full latency on resume.
                    hold        = 1'b1;
                    mdu_cnt_nxt = 8'd0;
                    state_nxt   = HALT;
                end else if (mdu_cnt <= 8'd1) begin
                    mdu_done    = 1'b1;
                    mdu_cnt_nxt = 8'd0;
                    state_nxt   = RUN;
                end else begin
                    hold        = 1'b1;
                    mdu_cnt_nxt = mdu_cnt - 8'd1;
                end
            end
            HALT: begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
                memwb_en = 1'b0;
                halted   = 1'b1;
                if (go) begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase

        // Hold pattern: freeze PC/IF/ID/EX, bubble into MEM, let MEM/WB drain.
        if (hold) begin
            pc_en     = 1'b0;
            ifid_en   = 1'b0;
            idex_en   = 1'b0;
            exmem_clr = 1'b1;
        end

        // While reset is asserted the pipeline sees the idle pattern.
        if (rst) begin
            pc_en     = 1'b1;
            ifid_en   = 1'b1;
            ifid_clr  = 1'b0;
            idex_en   = 1'b1;
            idex_clr  = 1'b0;
            exmem_en  = 1'b1;
            exmem_clr = 1'b0;
            memwb_en  = 1'b1;
            mdu_done  = 1'b0;
            halted    = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            mdu_cnt     <= 8'd0;
            resume_mask <= 1'b0;
        end else begin
            state       <= state_nxt;
            mdu_cnt     <= mdu_cnt_nxt;
            resume_mask <= (state == HALT) && go;
        end
    end

`ifdef PIPE_PERF_CNT_EN
    logic flush_evt;
    logic lu_evt;

    assign flush_evt = (state == RUN) && !halt_q && redirect_ex;
    assign lu_evt    = (state == RUN) && !halt_q && !redirect_ex && !mdu_start_ex && load_use;

    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
            lu_cnt    <= '0;
        end else begin
            if (state != HALT) begin
                cycle_cnt <= cycle_cnt + 1'b1;
                if (!pc_en) begin
                    stall_cnt <= stall_cnt + 1'b1;
                end
            end
            if (flush_evt) begin
                flush_cnt <= flush_cnt + 1'b1;
            end
            if (lu_evt) begin
                lu_cnt <= lu_cnt + 1'b1;
            end
        end
    end
`else
    assign cycle_cnt = '0;
    assign stall_cnt = '0;
    assign flush_cnt = '0;
    assign lu_cnt    = '0;
`endif

endmodule
